layer_seq_ctrl: RTL and testbench

- Sequencer for a fully-connected binary-output neural layer built around one shared multiply-accumulate unit.
- Accepts one packed input vector (the 20-bit GPIO input bus at defaults: 5 inputs x 4 bits) and reads signed weights and a bias per neuron from an external synchronous weight ROM.
- Serially computes each neuron's weighted sum, thresholds it, and presents the packed N_OUT-bit result (the LED bus at defaults) through a valid/ready handshake.
- Replaces a flat combinational layer when DSP/LUT budget matters.

---
 rtl/layer_seq_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequencer for a fully-connected, binary-output neural layer.
// One shared multiply-accumulate path walks every neuron serially. Weights
// and biases come from an external synchronous ROM with one cycle of read
// latency.
// Optional build macro LAYER_SEQ_SAT_EN: when defined, every accumulate step
// saturates to the signed ACC_W range. When undefined, the accumulator wraps
// modulo 2^ACC_W.
module layer_seq_ctrl #(
    parameter int N_IN   = 5,
    parameter int IN_W   = 4,
    parameter int N_OUT  = 4,
    parameter int W_W    = 4,
    parameter int ACC_W  = 12,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*IN_W-1:0]   in_vec,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_W-1:0]      w_addr,
    output logic                   w_rd,
    input  logic [W_W-1:0]         w_data,
    output logic [N_OUT-1:0]       out_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    // Product of a signed weight and a zero-extended input element.
    localparam int PROD_W = W_W + IN_W + 1;
    // One guard bit above the wider of accumulator and product.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam int K_W    = $clog2(N_IN + 2);
    localparam int J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [K_W-1:0] K_BIAS = K_W'(N_IN + 1);
    localparam logic [K_W-1:0] K_LREAD = K_W'(N_IN);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [N_IN*IN_W-1:0]    in_lat_q, in_lat_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [J_W-1:0]          j_q, j_d;
    logic [N_OUT-1:0]        res_q, res_d;
    logic [ADDR_W-1:0]       w_addr_q, w_addr_d;
    logic                    w_rd_q, w_rd_d;
    logic                    in_ready_q, in_ready_d;
    logic [N_OUT-1:0]        out_vec_q, out_vec_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    // Latched input vector split into its elements.
    logic [IN_W-1:0] elem [N_IN];
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_elem
        assign elem[gi] = in_lat_q[gi*IN_W +: IN_W];
    end

    logic [IN_W-1:0]         cur_elem;
    logic signed [W_W-1:0]   w_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0] addend;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_step;
    logic                    res_bit;

`ifdef LAYER_SEQ_SAT_EN
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(2 ** (ACC_W - 1)));
`endif

    // Datapath: pick the element for phase k, multiply, add product or bias.
    always_comb begin
        cur_elem = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (k_q == K_W'(i + 1)) begin
                cur_elem = elem[i];
            end
        end
        w_s    = signed'(w_data);
        prod   = PROD_W'(w_s) * PROD_W'(signed'({1'b0, cur_elem}));
        // The bias phase adds the raw ROM word; weight phases add the product.
        addend = (k_q == K_BIAS) ? SUM_W'(w_s) : SUM_W'(prod);
        sum    = SUM_W'(acc_q) + addend;
`ifdef LAYER_SEQ_SAT_EN
        if (sum > ACC_MAX) begin
            acc_step = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
            acc_step = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_step = sum[ACC_W-1:0];
        end
`else
        acc_step = sum[ACC_W-1:0];
`endif
        // Strictly positive: sign bit clear and not zero.
        res_bit = !acc_step[ACC_W-1] && (acc_step != '0);
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its registered outputs.
    always_comb begin
        state_d     = state_q;
        in_lat_d    = in_lat_q;
        acc_d       = acc_q;
        k_d         = k_q;
        j_d         = j_q;
        res_d       = res_q;
        w_addr_d    = w_addr_q;
        w_rd_d      = w_rd_q;
        out_vec_d   = out_vec_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d  = ST_RUN;
                    in_lat_d = in_vec;
                    acc_d    = '0;
                    k_d      = '0;
                    j_d      = '0;
                    res_d    = '0;
                    w_addr_d = '0;
                    w_rd_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (k_q == K_BIAS) begin
                    acc_d      = '0;
                    res_d[j_q] = res_bit;
                    k_d        = '0;
                    if (j_q == J_LAST) begin
                        state_d     = ST_DONE;
                        out_vec_d   = res_d;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        w_rd_d      = 1'b0;
                        w_addr_d    = '0;
                    end else begin
                        // Next neuron's base address follows its predecessor's bias.
                        j_d      = j_q + 1'b1;
                        w_rd_d   = 1'b1;
                        w_addr_d = w_addr_q + 1'b1;
                    end
                end else begin
                    if (k_q != '0) begin
                        acc_d = acc_step;
                    end
                    k_d = k_q + 1'b1;
                    if (k_q == K_LREAD) begin
                        // Bias read is in flight; the next phase only consumes it.
                        w_rd_d = 1'b0;
                    end else begin
                        w_addr_d = w_addr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_lat_q    <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            j_q         <= '0;
            res_q       <= '0;
            w_addr_q    <= '0;
            w_rd_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_lat_q    <= in_lat_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            j_q         <= j_d;
            res_q       <= res_d;
            w_addr_q    <= w_addr_d;
            w_rd_q      <= w_rd_d;
            in_ready_q  <= in_ready_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign w_addr    = w_addr_q;
    assign w_rd      = w_rd_q;
    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Testbench for layer_seq_ctrl: default instance plus an ACC_W=8 instance
// for accumulator overflow behaviour (wrap or LAYER_SEQ_SAT_EN saturation).
module tb_layer_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] in_vec, in_vec_b;
    logic        in_valid, in_valid_b;
    logic        in_ready, in_ready_b;
    logic [4:0]  w_addr, w_addr_b;
    logic        w_rd, w_rd_b;
    logic [3:0]  w_data, w_data_b;
    logic [3:0]  out_vec, out_vec_b;
    logic        out_valid, out_valid_b;
    logic        out_ready, out_ready_b;
    logic        busy, busy_b;

    logic [3:0] rom [32];
    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_b_q[$];
    logic [3:0] e_mon, e_mon_b;

    layer_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready), .w_addr(w_addr), .w_rd(w_rd), .w_data(w_data),
        .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    layer_seq_ctrl #(.ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .w_addr(w_addr_b), .w_rd(w_rd_b), .w_data(w_data_b),
        .out_vec(out_vec_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b)
    );

    // Synchronous ROM models; junk on the bus when not reading.
    always @(posedge clk) w_data   <= w_rd   ? rom[w_addr]   : 4'($urandom);
    always @(posedge clk) w_data_b <= w_rd_b ? rom[w_addr_b] : 4'($urandom);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitors: pop on every accepted result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_result: got %b, expected none", out_vec);
            end else begin
                e_mon = exp_q.pop_front();
                $display("result dut:   out_vec=%b expected=%b", out_vec, e_mon);
                check("out_vec", 32'(out_vec), 32'(e_mon));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_b && out_ready_b) begin
            if (exp_b_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_result_b: got %b, expected none", out_vec_b);
            end else begin
                e_mon_b = exp_b_q.pop_front();
                $display("result dut_b: out_vec=%b expected=%b", out_vec_b, e_mon_b);
                check("out_vec_b", 32'(out_vec_b), 32'(e_mon_b));
            end
        end
    end

    task automatic set_neuron(input int j, input logic [3:0] w, input logic [3:0] b);
        for (int i = 0; i < 5; i++) rom[j*6+i] = w;
        rom[j*6+5] = b;
    endtask

    // Offer a vector, wait (bounded) for in_ready, complete the handshake.
    task automatic send(input logic [19:0] v, input logic [3:0] e);
        int n = 0;
        exp_q.push_back(e);
        in_vec = v;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("handshake_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec = ~v;
    endtask

    // Walk the 28 RUN cycles checking the ROM trace, then the result cycle.
    task automatic run_checked(input string tag);
        for (int n = 0; n < 28; n++) begin
            int k = n % 7;
            int j = n / 7;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
            check({tag, "_out_valid_early"}, 32'(out_valid), 32'd0);
            check({tag, "_w_rd"}, 32'(w_rd), 32'(k <= 5));
            if (k <= 5) check({tag, "_w_addr"}, 32'(w_addr), 32'(j*6 + k));
            @(posedge clk); #1;
        end
        check({tag, "_out_valid_lat29"}, 32'(out_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_vec = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_vec_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_w_rd", 32'(w_rd), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_out_vec", 32'(out_vec), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // T1: weights +1, bias -8, inputs 2 -> 2 > 0 for every neuron
        for (int j = 0; j < 4; j++) set_neuron(j, 4'h1, 4'h8);
        send(20'h22222, 4'b1111);
        run_checked("t1");
        @(posedge clk); #1;
        check("t1_valid_drop", 32'(out_valid), 32'd0);
        check("t1_in_ready_back", 32'(in_ready), 32'd1);
        check("t1_out_vec_kept", 32'(out_vec), 32'hF);

        // T2: even neurons +1, odd neurons -1, bias 0, inputs 15
        for (int j = 0; j < 4; j++) set_neuron(j, (j % 2 == 0) ? 4'h1 : 4'hF, 4'h0);
        send(20'hFFFFF, 4'b0101);
        run_checked("t2");
        @(posedge clk); #1;

        // T3: sums exactly 0 give 0 (neurons 0 and 2), +1 gives 1; hold out_ready low
        set_neuron(0, 4'h1, 4'hB);
        set_neuron(1, 4'h1, 4'hC);
        set_neuron(2, 4'hF, 4'h5);
        set_neuron(3, 4'hF, 4'h6);
        out_ready = 1'b0;
        send(20'h11111, 4'b1010);
        run_checked("t3");
        exp_q.push_back(4'b1010);
        in_vec = 20'h11111;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_vec", 32'(out_vec), 32'hA);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_in_ready", 32'(in_ready), 32'd1);
        check("hold_release_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec = 20'h0;
        run_checked("t3b");
        @(posedge clk); #1;

        // T4: reset in RUN cycle 12, then a fresh vector with no carry-over
        in_vec = 20'hFFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("t4_pre_busy", 32'(busy), 32'd1);
        check("t4_pre_w_addr", 32'(w_addr), 32'd10);
        rst_n = 1'b0;
        #1;
        check("t4_rst_in_ready", 32'(in_ready), 32'd0);
        check("t4_rst_w_rd", 32'(w_rd), 32'd0);
        check("t4_rst_w_addr", 32'(w_addr), 32'd0);
        check("t4_rst_out_vec", 32'(out_vec), 32'd0);
        check("t4_rst_out_valid", 32'(out_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t4_idle_in_ready", 32'(in_ready), 32'd1);
        send(20'h11111, 4'b1010);
        run_checked("t4");
        @(posedge clk); #1;

        // T5: ACC_W=8 instance, weights +7, bias +7
        for (int j = 0; j < 4; j++) set_neuron(j, 4'h7, 4'h7);
`ifdef LAYER_SEQ_SAT_EN
        exp_b_q.push_back(4'b1111);   // clamps at 127
`else
        exp_b_q.push_back(4'b0000);   // 210 wraps to -46, final -39
`endif
        in_vec_b = 20'h000FF;
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b1_done", 32'(out_valid_b), 32'd1);
        @(posedge clk); #1;
        exp_b_q.push_back(4'b1111);   // wrap: 532 mod 256 = 20; sat: 127
        in_vec_b = 20'hFFFFF;
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2_done", 32'(out_valid_b), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("scoreboard_b_drained", 32'(exp_b_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
